// File: rtl/exmem_elastic_stage_pkg.sv
// Shared definitions for the EX/MEM elastic stage.
//   WB_REGWRITE              : bit of the writeback control that enables a register write
//   MEM_READ/WRITE/BRANCH    : bits of the memory control field
//   skid_state_e             : storage occupancy (EMPTY, ONE = main only, TWO = main + skid)
package exmem_pkg;

  localparam int unsigned WB_REGWRITE = 0;
  localparam int unsigned MEM_READ    = 0;
  localparam int unsigned MEM_WRITE   = 1;
  localparam int unsigned MEM_BRANCH  = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/exmem_elastic_stage_if.sv
// Handshake and field bundle between the EX stage, the EX/MEM elastic stage and the MEM stage.
//   Input side : in_valid/in_ready plus wb_i, mem_i, pc_i, zero_i, alu_i, src2_i, rd_i, funct_i
//   Output side: out_valid/out_ready plus wb_o, mem_o, pc_o, zero_o, addr_o, wdata_o, rd_o,
//                funct_o, br_taken_o and the forwarding tap fwd_valid/fwd_rd/fwd_data
//   slave  : view of the stage itself
//   master : view of the surrounding pipeline (EX producer + MEM consumer)
interface exmem_elastic_stage_if #(
  parameter int unsigned PC_WIDTH    = 9,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned RADDR_WIDTH = 5,
  parameter int unsigned FUNCT_WIDTH = 4,
  parameter int unsigned WB_WIDTH    = 2,
  parameter int unsigned MEM_WIDTH   = 3
);
  import exmem_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [WB_WIDTH-1:0]    wb_i;
  logic [MEM_WIDTH-1:0]   mem_i;
  logic [PC_WIDTH-1:0]    pc_i;
  logic                   zero_i;
  logic [DATA_WIDTH-1:0]  alu_i;
  logic [DATA_WIDTH-1:0]  src2_i;
  logic [RADDR_WIDTH-1:0] rd_i;
  logic [FUNCT_WIDTH-1:0] funct_i;

  logic                   out_valid;
  logic                   out_ready;
  logic [WB_WIDTH-1:0]    wb_o;
  logic [MEM_WIDTH-1:0]   mem_o;
  logic [PC_WIDTH-1:0]    pc_o;
  logic                   zero_o;
  logic [DATA_WIDTH-1:0]  addr_o;
  logic [DATA_WIDTH-1:0]  wdata_o;
  logic [RADDR_WIDTH-1:0] rd_o;
  logic [FUNCT_WIDTH-1:0] funct_o;
  logic                   br_taken_o;

  logic                   fwd_valid;
  logic [RADDR_WIDTH-1:0] fwd_rd;
  logic [DATA_WIDTH-1:0]  fwd_data;

  modport slave (
    input  in_valid, wb_i, mem_i, pc_i, zero_i, alu_i, src2_i, rd_i, funct_i, out_ready,
    output in_ready, out_valid, wb_o, mem_o, pc_o, zero_o, addr_o, wdata_o, rd_o, funct_o,
           br_taken_o, fwd_valid, fwd_rd, fwd_data
  );

  modport master (
    output in_valid, wb_i, mem_i, pc_i, zero_i, alu_i, src2_i, rd_i, funct_i, out_ready,
    input  in_ready, out_valid, wb_o, mem_o, pc_o, zero_o, addr_o, wdata_o, rd_o, funct_o,
           br_taken_o, fwd_valid, fwd_rd, fwd_data
  );

endinterface

// File: rtl/exmem_elastic_stage_skid.sv
// Generic 2-entry valid/ready skid store with flush.
//   clk, rst        : clock, synchronous active-high reset (clears data and occupancy)
//   flush           : drop everything held and the beat offered this cycle
//   in_valid/in_ready/in_data    : producer side; in_ready depends only on registers
//   out_valid/out_ready/out_data : consumer side; out_data is always the main (head) entry
module skid_buffer
  import exmem_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept;
  logic         consume;

  // Occupancy is the state itself: main valid in ONE/TWO, skid valid only in TWO.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          main_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = TWO;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (consume) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops the incoming beat entirely, so stored data is left untouched and the
    // invalid outputs keep showing the last stored values.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/exmem_elastic_stage.sv
// EX/MEM pipeline boundary with valid/ready on both sides.
//   clk, rst : clock, synchronous active-high reset
//   flush    : squash held beats and any beat offered in the same cycle
//   bus      : exmem_elastic_stage_if slave view (EX-side inputs, MEM-side outputs,
//              branch-taken and forwarding tap for the EX hazard unit)
// All fields are packed into a single payload held by skid_buffer; control fields are
// forced to zero while no beat is valid so MEM/WB see no side effects.
module exmem_elastic_stage
  import exmem_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 9,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned RADDR_WIDTH = 5,
  parameter int unsigned FUNCT_WIDTH = 4,
  parameter int unsigned WB_WIDTH    = 2,
  parameter int unsigned MEM_WIDTH   = 3
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  flush,
  exmem_elastic_stage_if.slave bus
);

  localparam int unsigned W = WB_WIDTH + MEM_WIDTH + PC_WIDTH + 1 + 2 * DATA_WIDTH
                            + RADDR_WIDTH + FUNCT_WIDTH;

  logic [W-1:0]           in_payload;
  logic [W-1:0]           head;
  logic                   head_valid;

  logic [WB_WIDTH-1:0]    head_wb;
  logic [MEM_WIDTH-1:0]   head_mem;
  logic [PC_WIDTH-1:0]    head_pc;
  logic                   head_zero;
  logic [DATA_WIDTH-1:0]  head_alu;
  logic [DATA_WIDTH-1:0]  head_src2;
  logic [RADDR_WIDTH-1:0] head_rd;
  logic [FUNCT_WIDTH-1:0] head_funct;

  assign in_payload = {bus.wb_i, bus.mem_i, bus.pc_i, bus.zero_i,
                       bus.alu_i, bus.src2_i, bus.rd_i, bus.funct_i};

  skid_buffer #(
    .W(W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_payload),
    .out_valid (head_valid),
    .out_ready (bus.out_ready),
    .out_data  (head)
  );

  assign {head_wb, head_mem, head_pc, head_zero,
          head_alu, head_src2, head_rd, head_funct} = head;

  assign bus.out_valid  = head_valid;
  assign bus.wb_o       = head_valid ? head_wb  : '0;
  assign bus.mem_o      = head_valid ? head_mem : '0;
  assign bus.pc_o       = head_pc;
  assign bus.zero_o     = head_zero;
  assign bus.addr_o     = head_alu;
  assign bus.wdata_o    = head_src2;
  assign bus.rd_o       = head_rd;
  assign bus.funct_o    = head_funct;

  assign bus.br_taken_o = head_valid & head_mem[MEM_BRANCH] & head_zero;

  // x0 is hard-wired zero, so a write to it must never be forwarded.
  assign bus.fwd_valid  = head_valid & head_wb[WB_REGWRITE] & (head_rd != '0);
  assign bus.fwd_rd     = head_rd;
  assign bus.fwd_data   = head_alu;

endmodule

// File: tb/tb_exmem_elastic_stage.sv
module tb_exmem_elastic_stage;
  import exmem_pkg::*;

  localparam int unsigned PC_W    = 9;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RADDR_W = 5;
  localparam int unsigned FUNCT_W = 4;
  localparam int unsigned WB_W    = 2;
  localparam int unsigned MEM_W   = 3;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  exmem_elastic_stage_if #(
    .PC_WIDTH(PC_W), .DATA_WIDTH(DATA_W), .RADDR_WIDTH(RADDR_W),
    .FUNCT_WIDTH(FUNCT_W), .WB_WIDTH(WB_W), .MEM_WIDTH(MEM_W)
  ) bus ();

  exmem_elastic_stage #(
    .PC_WIDTH(PC_W), .DATA_WIDTH(DATA_W), .RADDR_WIDTH(RADDR_W),
    .FUNCT_WIDTH(FUNCT_W), .WB_WIDTH(WB_W), .MEM_WIDTH(MEM_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [8:0]  pc;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] src2;
    logic [4:0]  rd;
    logic [3:0]  funct;
    logic        br;
    logic        fwd;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_b;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_pop    = 0;
  int unsigned pop_mark;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic skid_state_e decode();
    if (!bus.out_valid) return EMPTY;
    if (bus.in_ready)   return ONE;
    return TWO;
  endfunction

  function automatic beat_t mk(input logic [1:0] wb, input logic [2:0] mem, input logic [8:0] pc,
                               input logic zero, input logic [31:0] alu, input logic [31:0] src2,
                               input logic [4:0] rd, input logic [3:0] funct,
                               input logic br, input logic fwd);
    beat_t b;
    b.wb = wb; b.mem = mem; b.pc = pc; b.zero = zero; b.alu = alu; b.src2 = src2;
    b.rd = rd; b.funct = funct; b.br = br; b.fwd = fwd;
    return b;
  endfunction

  task automatic put_fields(input beat_t b);
    bus.wb_i = b.wb; bus.mem_i = b.mem; bus.pc_i = b.pc; bus.zero_i = b.zero;
    bus.alu_i = b.alu; bus.src2_i = b.src2; bus.rd_i = b.rd; bus.funct_i = b.funct;
  endtask

  // Offer one beat; expected response is queued at the cycle it is accepted.
  task automatic send(input beat_t b);
    put_fields(b);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) begin
        exp_q.push_back(b);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Monitor: compares every consumed head beat against the scoreboard, and checks
  // control gating on idle cycles.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got addr 0x%0h, expected no beat (t=%0t)",
                   bus.addr_o, $time);
        end else begin
          mon_b = exp_q.pop_front();
          n_pop++;
          chk("beat_data", {bus.addr_o, bus.wdata_o}, {mon_b.alu, mon_b.src2});
          chk("beat_ctl",
              {bus.wb_o, bus.mem_o, bus.pc_o, bus.zero_o, bus.rd_o, bus.funct_o,
               bus.br_taken_o, bus.fwd_valid, bus.fwd_rd},
              {mon_b.wb, mon_b.mem, mon_b.pc, mon_b.zero, mon_b.rd, mon_b.funct,
               mon_b.br, mon_b.fwd, mon_b.rd});
          chk("beat_fwd_data", bus.fwd_data, mon_b.alu);
        end
      end else if (!bus.out_valid) begin
        chk("idle_gating", {bus.wb_o, bus.mem_o, bus.br_taken_o, bus.fwd_valid}, 64'd0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    put_fields('0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_addr", bus.addr_o, 32'h0);
    chk("rst_state", decode(), EMPTY);

    // 1: single beat, one-cycle latency, forwarding tap
    bus.out_ready = 1'b1;
    send(mk(2'b01, 3'b000, 9'h0, 1'b0, 32'h0000_0040, 32'h0, 5'd5, 4'h0, 1'b0, 1'b1));
    chk("t1_out_valid", bus.out_valid, 1'b1);
    chk("t1_addr", bus.addr_o, 32'h40);
    chk("t1_fwd_valid", bus.fwd_valid, 1'b1);
    chk("t1_fwd_rd", bus.fwd_rd, 5'd5);
    step();
    chk("t1_drained", exp_q.size(), 0);

    // 2: eight-beat stream at full throughput
    pop_mark = n_pop;
    for (int i = 0; i < 8; i++) begin
      chk("t2_in_ready", bus.in_ready, 1'b1);
      send(mk(2'b01, 3'b000, 9'(i), 1'b0, 32'(i), ~32'(i), 5'd3, 4'(i), 1'b0, 1'b1));
      chk("t2_out_valid", bus.out_valid, 1'b1);
    end
    step();
    chk("t2_pop_count", n_pop - pop_mark, 8);
    chk("t2_drained", exp_q.size(), 0);

    // 3: stall with two beats held, then release
    bus.out_ready = 1'b0;
    send(mk(2'b00, 3'b010, 9'h11, 1'b0, 32'd100, 32'hA, 5'd7, 4'h1, 1'b0, 1'b0));
    chk("t3_in_ready_one", bus.in_ready, 1'b1);
    send(mk(2'b00, 3'b001, 9'h12, 1'b1, 32'd101, 32'hB, 5'd8, 4'h2, 1'b0, 1'b0));
    chk("t3_in_ready_two", bus.in_ready, 1'b0);
    chk("t3_state_two", decode(), TWO);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t3_hold_addr", bus.addr_o, 32'd100);
      chk("t3_hold_mem", bus.mem_o, 3'b010);
    end
    bus.out_ready = 1'b1;
    chk("t3_no_comb_ready", bus.in_ready, 1'b0);
    step();
    chk("t3_in_ready_back", bus.in_ready, 1'b1);
    chk("t3_second_head", bus.addr_o, 32'd101);
    step();
    chk("t3_state_empty", decode(), EMPTY);
    chk("t3_drained", exp_q.size(), 0);

    // 4a: flush with two beats held and a beat offered
    bus.out_ready = 1'b0;
    send(mk(2'b01, 3'b010, 9'h21, 1'b1, 32'd200, 32'h1, 5'd9, 4'h3, 1'b0, 1'b1));
    send(mk(2'b01, 3'b001, 9'h22, 1'b0, 32'd201, 32'h2, 5'd10, 4'h4, 1'b0, 1'b1));
    chk("t4_state_two", decode(), TWO);
    put_fields(mk(2'b01, 3'b011, 9'h1FF, 1'b1, 32'hBAD0, 32'hBAD1, 5'd31, 4'hF, 1'b0, 1'b0));
    bus.in_valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    chk("t4_out_valid", bus.out_valid, 1'b0);
    chk("t4_wb_o", bus.wb_o, 2'b00);
    chk("t4_mem_o", bus.mem_o, 3'b000);
    chk("t4_in_ready", bus.in_ready, 1'b1);
    chk("t4_fwd_valid", bus.fwd_valid, 1'b0);
    chk("t4_addr_held", bus.addr_o, 32'd200);

    // 4b: flush in ONE while a new beat is acceptable; the offered beat is dropped
    send(mk(2'b00, 3'b000, 9'h31, 1'b0, 32'd300, 32'h3, 5'd11, 4'h5, 1'b0, 1'b0));
    put_fields(mk(2'b01, 3'b011, 9'h1FE, 1'b1, 32'hBAD2, 32'hBAD3, 5'd30, 4'hE, 1'b0, 1'b0));
    bus.in_valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    chk("t4b_out_valid", bus.out_valid, 1'b0);
    chk("t4b_addr_held", bus.addr_o, 32'd300);

    // 4c: consume in the flush cycle still completes downstream
    bus.out_ready = 1'b1;
    send(mk(2'b01, 3'b000, 9'h41, 1'b0, 32'd400, 32'h4, 5'd12, 4'h6, 1'b0, 1'b1));
    put_fields(mk(2'b01, 3'b011, 9'h1FD, 1'b1, 32'hBAD4, 32'hBAD5, 5'd29, 4'hD, 1'b0, 1'b0));
    bus.in_valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("t4c_consumed", exp_q.size(), 0);
    chk("t4c_out_valid", bus.out_valid, 1'b0);
    repeat (3) step();

    // 5: branch-taken and x0 forwarding suppression
    send(mk(2'b00, 3'b100, 9'h55, 1'b1, 32'd500, 32'h5, 5'd13, 4'h7, 1'b1, 1'b0));
    chk("t5_br_taken", bus.br_taken_o, 1'b1);
    send(mk(2'b00, 3'b100, 9'h56, 1'b0, 32'd501, 32'h6, 5'd14, 4'h8, 1'b0, 1'b0));
    chk("t5_br_not_taken", bus.br_taken_o, 1'b0);
    send(mk(2'b01, 3'b000, 9'h57, 1'b0, 32'd502, 32'h7, 5'd0, 4'h9, 1'b0, 1'b0));
    chk("t5_fwd_rd0", bus.fwd_valid, 1'b0);
    step();
    chk("t5_drained", exp_q.size(), 0);

    // 6: reset while in TWO
    bus.out_ready = 1'b0;
    send(mk(2'b11, 3'b111, 9'h1FF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 4'hF, 1'b1, 1'b1));
    send(mk(2'b11, 3'b111, 9'h1AA, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 5'd21, 4'hA, 1'b1, 1'b1));
    chk("t6_state_two", decode(), TWO);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    chk("t6_out_valid", bus.out_valid, 1'b0);
    chk("t6_in_ready", bus.in_ready, 1'b1);
    chk("t6_data_zero", {bus.addr_o, bus.wdata_o}, 64'd0);
    chk("t6_ctl_zero",
        {bus.wb_o, bus.mem_o, bus.pc_o, bus.zero_o, bus.rd_o, bus.funct_o,
         bus.br_taken_o, bus.fwd_valid, bus.fwd_rd}, 64'd0);
    chk("t6_fwd_data_zero", bus.fwd_data, 32'd0);

    // Nothing held after reset must ever emerge
    bus.out_ready = 1'b1;
    repeat (4) step();
    chk("final_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
